// File: rtl/clk_rst_seq_pkg.sv
// Purpose: shared encodings and defaults for the clock-enable / reset sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clk_rst_seq_pkg;

   // Reset-sequencer FSM states.
   typedef enum logic [1:0] {
      SEQ_HOLD    = 2'd0,
      SEQ_RELEASE = 2'd1,
      SEQ_RUN     = 2'd2
   } seq_state_t;

   // Master-clock divisors for the emulated CPU and PPU.
   localparam int NES_CPU_DIV = 12;
   localparam int NES_PPU_DIV = 4;

   // Packs two 8-bit per-channel fields as {ch1, ch0}, ch0 in the low byte.
   function automatic logic [15:0] pack2(input logic [7:0] ch1, input logic [7:0] ch0);
      return {ch1, ch0};
   endfunction

   localparam logic [15:0] DEF_CH_DIV   = pack2(8'(NES_PPU_DIV), 8'(NES_CPU_DIV));
   localparam logic [15:0] DEF_CH_PHASE = pack2(8'd0, 8'd0);

endpackage

// File: rtl/clk_rst_seq_clk_en_div.sv
// Purpose: one channel's programmable clock-enable divider with deferred divisor update.
// Latency: clk_en is a zero-latency decode of the registered counter; writes land at the next wrap.
// Backpressure: none; run=0 freezes the counter and forces clk_en low.
//
// Ports:
//   clk_mst, rst_mst : master clock, async active-high reset
//   run              : counter advance enable
//   wr, wr_data      : divisor write strobe and value for this channel
//   clk_en           : one-cycle enable strobe
module clk_en_div #(
   parameter int               DIV_W      = 8,
   parameter logic [DIV_W-1:0] INIT_DIV   = 8'd12,
   parameter logic [DIV_W-1:0] INIT_PHASE = 8'd0
) (
   input  logic             clk_mst,
   input  logic             rst_mst,
   input  logic             run,
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_data,
   output logic             clk_en
);

   // A zero divisor behaves as divide-by-one.
   localparam logic [DIV_W-1:0] INIT_EFF = (INIT_DIV == '0) ? DIV_W'(1) : INIT_DIV;
   localparam logic [DIV_W-1:0] INIT_CNT = INIT_PHASE % INIT_EFF;

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] pend;
   logic             pend_vld;
   logic [DIV_W-1:0] eff_div;
   logic [DIV_W-1:0] term;

   assign eff_div = (div == '0) ? DIV_W'(1) : div;
   assign term    = eff_div - DIV_W'(1);
   assign clk_en  = run && (cnt == term);

   always_ff @(posedge clk_mst or posedge rst_mst) begin
      if (rst_mst) begin
         cnt      <= INIT_CNT;
         div      <= INIT_DIV;
         pend     <= '0;
         pend_vld <= 1'b0;
      end else begin
         if (run) begin
            // The wrap and a divisor swap both restart the count at 0.
            cnt <= clk_en ? '0 : cnt + DIV_W'(1);
         end
         // Only a value pending before this strobe is applied; a write in the
         // strobe cycle itself stays pending until the following wrap.
         if (clk_en && pend_vld) begin
            div <= pend;
         end
         if (wr) begin
            pend     <= wr_data;
            pend_vld <= 1'b1;
         end else if (clk_en) begin
            pend_vld <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/clk_rst_seq.sv
// Purpose: per-channel clock-enable generation plus ordered, enable-aligned reset release.
// Latency: clk_en zero-latency decode; rst_en[i] falls the cycle after its release strobe.
// Backpressure: none; run=0 freezes counters, suppresses enables and stalls the release.
//
// Ports:
//   clk_mst, rst_mst     : master clock, async active-high reset
//   run                  : 1 = counters advance, 0 = halt
//   soft_rst             : one-cycle request to restart the reset sequence
//   div_wr/div_sel/div_data : runtime divisor write (out-of-range div_sel ignored)
//   clk_en[NUM_CH]       : per-channel enable strobes
//   rst_en[NUM_CH]       : per-channel active-high resets
//   seq_done             : all channel resets released
module clk_rst_seq
   import clk_rst_seq_pkg::*;
#(
   parameter int                      NUM_CH   = 2,
   parameter int                      DIV_W    = 8,
   parameter logic [NUM_CH*DIV_W-1:0] CH_DIV   = DEF_CH_DIV,
   parameter logic [NUM_CH*DIV_W-1:0] CH_PHASE = DEF_CH_PHASE,
   parameter int                      RST_HOLD = 16
) (
   input  logic              clk_mst,
   input  logic              rst_mst,
   input  logic              run,
   input  logic              soft_rst,
   input  logic              div_wr,
   input  logic [2:0]        div_sel,
   input  logic [DIV_W-1:0]  div_data,
   output logic [NUM_CH-1:0] clk_en,
   output logic [NUM_CH-1:0] rst_en,
   output logic              seq_done
);

   localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CH - 1);

   // ---------------- per-channel dividers ----------------
   logic [NUM_CH-1:0] ch_wr;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      // Channels >= NUM_CH never decode, so out-of-range selects are dropped.
      assign ch_wr[g] = div_wr && (div_sel == 3'(g));

      clk_en_div #(
         .DIV_W      (DIV_W),
         .INIT_DIV   (CH_DIV[g*DIV_W +: DIV_W]),
         .INIT_PHASE (CH_PHASE[g*DIV_W +: DIV_W])
      ) u_div (
         .clk_mst (clk_mst),
         .rst_mst (rst_mst),
         .run     (run),
         .wr      (ch_wr[g]),
         .wr_data (div_data),
         .clk_en  (clk_en[g])
      );
   end

   // ---------------- reset sequencer ----------------
   seq_state_t        state,    state_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic [IDX_W-1:0]  idx,      idx_nxt;
   logic [NUM_CH-1:0] rst_nxt;
   logic              done_nxt;

   always_ff @(posedge clk_mst or posedge rst_mst) begin
      if (rst_mst) begin
         state    <= SEQ_HOLD;
         hold_cnt <= '0;
         idx      <= '0;
         rst_en   <= '1;
         seq_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         idx      <= idx_nxt;
         rst_en   <= rst_nxt;
         seq_done <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      idx_nxt   = idx;
      rst_nxt   = rst_en;
      done_nxt  = seq_done;

      case (state)
         SEQ_HOLD: begin
            // Counts on master cycles, independent of run.
            if (hold_cnt == HOLD_LAST) begin
               state_nxt = SEQ_RELEASE;
               idx_nxt   = '0;
            end else begin
               hold_nxt = hold_cnt + HOLD_W'(1);
            end
         end
         SEQ_RELEASE: begin
            // Release is aligned to the channel's own enable, so a halted
            // sequencer simply waits here.
            if (clk_en[idx]) begin
               rst_nxt[idx] = 1'b0;
               if (idx == IDX_LAST) begin
                  state_nxt = SEQ_RUN;
                  done_nxt  = 1'b1;
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end
         end
         SEQ_RUN: begin
            done_nxt = 1'b1;
         end
         default: begin
            state_nxt = SEQ_HOLD;
         end
      endcase

      // Soft reset overrides any release happening on the same edge.
      if (soft_rst) begin
         state_nxt = SEQ_HOLD;
         hold_nxt  = '0;
         idx_nxt   = '0;
         rst_nxt   = '1;
         done_nxt  = 1'b0;
      end
   end

endmodule

// File: tb/tb_clk_rst_seq.sv
module tb_clk_rst_seq;

   logic       clk_mst = 1'b0;
   logic       rst_mst;
   logic       run;
   logic       soft_rst;
   logic       div_wr;
   logic [2:0] div_sel;
   logic [7:0] div_data;
   logic [1:0] clk_en;
   logic [1:0] rst_en;
   logic       seq_done;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   clk_rst_seq dut (
      .clk_mst  (clk_mst),
      .rst_mst  (rst_mst),
      .run      (run),
      .soft_rst (soft_rst),
      .div_wr   (div_wr),
      .div_sel  (div_sel),
      .div_data (div_data),
      .clk_en   (clk_en),
      .rst_en   (rst_en),
      .seq_done (seq_done)
   );

   always #5 clk_mst = ~clk_mst;

   // Observed vector: {clk_en[1], clk_en[0], rst_en[1], rst_en[0], seq_done}
   task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_mst);
      #2;
      cyc++;
   endtask

   task automatic idle_inputs();
      soft_rst = 1'b0;
      div_wr   = 1'b0;
      div_sel  = 3'd0;
      div_data = 8'd0;
   endtask

   task automatic do_reset();
      rst_mst = 1'b1;
      run     = 1'b1;
      idle_inputs();
      @(posedge clk_mst);
      @(posedge clk_mst);
      #3;
      chk("reset_state", {clk_en, rst_en, seq_done}, 5'b00110);
      @(posedge clk_mst);
      #2;
      rst_mst = 1'b0;
      cyc     = 0;
   endtask

   logic ce0, ce1, re0, re1, sd;
   int   v;

   initial begin
      // ---------- defaults, divisor writes, soft reset ----------
      do_reset();
      while (cyc <= 112) begin
         idle_inputs();
         if (cyc == 40) begin div_wr = 1'b1; div_sel = 3'd1; div_data = 8'd6; end
         if (cyc == 60) begin div_wr = 1'b1; div_sel = 3'd0; div_data = 8'd0; end
         if (cyc == 62) begin div_wr = 1'b1; div_sel = 3'd5; div_data = 8'd1; end
         if (cyc == 80) soft_rst = 1'b1;
         // write in the same cycle as a ch1 strobe: deferred to the next wrap
         if (cyc == 97) begin div_wr = 1'b1; div_sel = 3'd1; div_data = 8'd3; end
         #1;
         ce0 = (cyc <= 71) ? (cyc % 12 == 11) : 1'b1;
         if (cyc <= 43)       ce1 = (cyc % 4 == 3);
         else if (cyc <= 103) ce1 = ((cyc - 43) % 6 == 0);
         else                 ce1 = ((cyc - 104) % 3 == 2);
         if (cyc < 81) begin
            re0 = (cyc < 24); re1 = (cyc < 28); sd = (cyc >= 28);
         end else begin
            re0 = (cyc < 98); re1 = (cyc < 104); sd = (cyc >= 104);
         end
         chk("main_seq", {clk_en, rst_en, seq_done}, {ce1, ce0, re1, re0, sd});
         tick();
      end

      // ---------- halt during release ----------
      do_reset();
      while (cyc <= 45) begin
         idle_inputs();
         run = !(cyc >= 20 && cyc <= 29);
         #1;
         if (run) begin
            v   = (cyc < 20) ? cyc : cyc - 10;
            ce0 = (v % 12 == 11);
            ce1 = (v % 4 == 3);
         end else begin
            ce0 = 1'b0;
            ce1 = 1'b0;
         end
         re0 = (cyc < 34); re1 = (cyc < 38); sd = (cyc >= 38);
         chk("halt_seq", {clk_en, rst_en, seq_done}, {ce1, ce0, re1, re0, sd});
         tick();
      end
      run = 1'b1;

      // ---------- async reset mid-release, pending write discarded ----------
      do_reset();
      while (cyc <= 27) begin
         idle_inputs();
         if (cyc == 26) begin div_wr = 1'b1; div_sel = 3'd0; div_data = 8'd5; end
         #1;
         chk("pre_async", {clk_en, rst_en, seq_done},
             {1'(cyc % 4 == 3), 1'(cyc % 12 == 11), 1'(cyc < 28), 1'(cyc < 24), 1'b0});
         if (cyc < 27) tick();
         else break;
      end
      #1;
      rst_mst = 1'b1;
      #1;
      chk("async_rst", {clk_en, rst_en, seq_done}, 5'b00110);
      @(posedge clk_mst);
      #2;
      rst_mst = 1'b0;
      cyc     = 0;
      while (cyc <= 24) begin
         idle_inputs();
         #1;
         chk("post_async", {clk_en, rst_en, seq_done},
             {1'(cyc % 4 == 3), 1'(cyc % 12 == 11), 1'(cyc < 28), 1'(cyc < 24), 1'b0});
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
